// File: rtl/mem_access_pkg.sv
// Shared defines for the memory stage: bus widths, writeback constants,
// mem_op encodings, FSM states and the latched transaction context.
package mem_access_pkg;

    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned MemOpBus   = 4;
    localparam int unsigned SelBus     = 4;

    localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic                  WriteEnable  = 1'b1;

    localparam logic [MemOpBus-1:0] OP_NONE = 4'd0;
    localparam logic [MemOpBus-1:0] OP_LB   = 4'd1;
    localparam logic [MemOpBus-1:0] OP_LBU  = 4'd2;
    localparam logic [MemOpBus-1:0] OP_LH   = 4'd3;
    localparam logic [MemOpBus-1:0] OP_LHU  = 4'd4;
    localparam logic [MemOpBus-1:0] OP_LW   = 4'd5;
    localparam logic [MemOpBus-1:0] OP_SB   = 4'd6;
    localparam logic [MemOpBus-1:0] OP_SH   = 4'd7;
    localparam logic [MemOpBus-1:0] OP_SW   = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    // Context captured when a transaction is launched, used on completion.
    typedef struct packed {
        logic [MemOpBus-1:0]   op;
        logic [1:0]            addr_lo;
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
    } mem_ctx_t;

    function automatic logic is_load(input logic [MemOpBus-1:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input logic [MemOpBus-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane select, store replication and load extension.
// MEM_ALIGN_CHECK_EN enables detection of misaligned half/word accesses.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [MemOpBus-1:0] req_op,
    input  logic [1:0]          req_addr_lo,
    input  logic [RegBus-1:0]   sdata,
    output logic [SelBus-1:0]   sel_c,
    output logic [RegBus-1:0]   wdata_c,
    output logic                misaligned_c,
    input  logic [MemOpBus-1:0] rsp_op,
    input  logic [1:0]          rsp_addr_lo,
    input  logic [RegBus-1:0]   rdata,
    output logic [RegBus-1:0]   load_data_c
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Request side: lanes and replicated store data
    always_comb begin
        sel_c   = '0;
        wdata_c = sdata;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: begin
                case (req_addr_lo)
                    2'd0:    sel_c = 4'b1000;
                    2'd1:    sel_c = 4'b0100;
                    2'd2:    sel_c = 4'b0010;
                    default: sel_c = 4'b0001;
                endcase
                wdata_c = {4{sdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                sel_c   = req_addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata_c = {2{sdata[15:0]}};
            end
            OP_LW, OP_SW: sel_c = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        misaligned_c = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        case (req_op)
            OP_LH, OP_LHU, OP_SH: misaligned_c = req_addr_lo[0];
            OP_LW, OP_SW:         misaligned_c = |req_addr_lo;
            default: ;
        endcase
`endif
    end

    // Response side: pick the addressed lane and extend it
    always_comb begin
        case (rsp_addr_lo)
            2'd0:    rd_byte = rdata[31:24];
            2'd1:    rd_byte = rdata[23:16];
            2'd2:    rd_byte = rdata[15:8];
            default: rd_byte = rdata[7:0];
        endcase
        rd_half = rsp_addr_lo[1] ? rdata[15:0] : rdata[31:16];
        case (rsp_op)
            OP_LB:   load_data_c = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_data_c = {24'd0, rd_byte};
            OP_LH:   load_data_c = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_data_c = {16'd0, rd_half};
            default: load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage access unit: single req/ack bus transactions with timeout,
// pipeline stall request and registered writeback. Honors MEM_ALIGN_CHECK_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [RegBus-1:0]     mem_wdata,
    input  logic [MemOpBus-1:0]   mem_op,
    input  logic [RegBus-1:0]     mem_addr,
    input  logic [RegBus-1:0]     mem_sdata,
    output logic [RegAddrBus-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [RegBus-1:0]     wb_wdata,
    output logic                  stall_req,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [RegBus-1:0]     bus_addr,
    output logic [SelBus-1:0]     bus_sel,
    output logic [RegBus-1:0]     bus_wdata,
    input  logic [RegBus-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output logic                  bus_err,
    output logic                  align_exc
);

    localparam int unsigned CNT_W = 8;

    state_e                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    mem_ctx_t                ctx, ctx_nxt;
    logic [RegAddrBus-1:0]   wb_wd_nxt;
    logic                    wb_wreg_nxt;
    logic [RegBus-1:0]       wb_wdata_nxt;
    logic                    bus_req_nxt, bus_we_nxt, bus_err_nxt, align_exc_nxt;
    logic [RegBus-1:0]       bus_addr_nxt, bus_wdata_nxt;
    logic [SelBus-1:0]       bus_sel_nxt;

    logic [SelBus-1:0]       sel_c;
    logic [RegBus-1:0]       wdata_c;
    logic [RegBus-1:0]       load_data_c;
    logic                    misaligned_c;

    mem_lane_align u_lane (
        .req_op       (mem_op),
        .req_addr_lo  (mem_addr[1:0]),
        .sdata        (mem_sdata),
        .sel_c        (sel_c),
        .wdata_c      (wdata_c),
        .misaligned_c (misaligned_c),
        .rsp_op       (ctx.op),
        .rsp_addr_lo  (ctx.addr_lo),
        .rdata        (bus_rdata),
        .load_data_c  (load_data_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ctx_nxt       = ctx;
        wb_wd_nxt     = wb_wd;
        wb_wreg_nxt   = wb_wreg;
        wb_wdata_nxt  = wb_wdata;
        bus_req_nxt   = bus_req;
        bus_we_nxt    = bus_we;
        bus_addr_nxt  = bus_addr;
        bus_sel_nxt   = bus_sel;
        bus_wdata_nxt = bus_wdata;
        bus_err_nxt   = 1'b0;
        align_exc_nxt = 1'b0;
        stall_req     = 1'b0;

        case (state)
            IDLE: begin
                if (is_load(mem_op) || is_store(mem_op)) begin
                    wb_wreg_nxt = WriteDisable;
                    if (misaligned_c) begin
                        align_exc_nxt = 1'b1;
                    end else begin
                        stall_req     = 1'b1;
                        bus_req_nxt   = 1'b1;
                        bus_we_nxt    = is_store(mem_op);
                        bus_addr_nxt  = {mem_addr[RegBus-1:2], 2'b00};
                        bus_sel_nxt   = sel_c;
                        bus_wdata_nxt = wdata_c;
                        ctx_nxt       = '{op: mem_op, addr_lo: mem_addr[1:0],
                                          wd: mem_wd, wreg: mem_wreg};
                        cnt_nxt       = '0;
                        state_nxt     = BUS;
                    end
                end else begin
                    wb_wd_nxt    = mem_wd;
                    wb_wreg_nxt  = mem_wreg;
                    wb_wdata_nxt = mem_wdata;
                end
            end
            BUS: begin
                if (bus_ack) begin
                    bus_req_nxt = 1'b0;
                    bus_we_nxt  = 1'b0;
                    wb_wd_nxt   = ctx.wd;
                    wb_wreg_nxt = ctx.wreg;
                    if (is_load(ctx.op)) begin
                        wb_wdata_nxt = load_data_c;
                    end
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Abort: release the pipeline in this final cycle
                    bus_req_nxt = 1'b0;
                    bus_we_nxt  = 1'b0;
                    bus_err_nxt = 1'b1;
                    wb_wreg_nxt = WriteDisable;
                    state_nxt   = IDLE;
                end else begin
                    stall_req   = 1'b1;
                    wb_wreg_nxt = WriteDisable;
                    cnt_nxt     = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ctx       <= '0;
            wb_wd     <= NOPRegAddr;
            wb_wreg   <= WriteDisable;
            wb_wdata  <= ZeroWord;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= ZeroWord;
            bus_sel   <= '0;
            bus_wdata <= ZeroWord;
            bus_err   <= 1'b0;
            align_exc <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ctx       <= ctx_nxt;
            wb_wd     <= wb_wd_nxt;
            wb_wreg   <= wb_wreg_nxt;
            wb_wdata  <= wb_wdata_nxt;
            bus_req   <= bus_req_nxt;
            bus_we    <= bus_we_nxt;
            bus_addr  <= bus_addr_nxt;
            bus_sel   <= bus_sel_nxt;
            bus_wdata <= bus_wdata_nxt;
            bus_err   <= bus_err_nxt;
            align_exc <= align_exc_nxt;
        end
    end

endmodule
